// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth MULT/MULTU unit.
// Holds the FSM state encoding, the iteration count and the Booth digit code.
package mul_pkg;

  localparam int MUL_ITER = 17;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Digit magnitude is selected by two/one, sign by neg; all-zero means digit 0.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_t;

endpackage

// File: rtl/mul_alu_booth_enc.sv
// Radix-4 Booth recoder: maps {b[2i+1], b[2i], b[2i-1]} to a {neg, two, one} digit.
// Purely combinational; the partial-product mux lives in the parent.
module mul_alu_booth_enc
  import mul_pkg::*;
(
  input  logic [2:0] window,
  output booth_t     digit
);

  always_comb begin
    digit = '0;
    unique case (window)
      3'b000, 3'b111: digit = '0;
      3'b001, 3'b010: digit = '{neg: 1'b0, two: 1'b0, one: 1'b1};
      3'b011:         digit = '{neg: 1'b0, two: 1'b1, one: 1'b0};
      3'b100:         digit = '{neg: 1'b1, two: 1'b1, one: 1'b0};
      3'b101, 3'b110: digit = '{neg: 1'b1, two: 1'b0, one: 1'b1};
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/mul_alu.sv
// Multi-cycle 32x32->64 multiplier (MULT/MULTU), radix-4 Booth, two bits per cycle.
// start/mul_is_running/done: start is a one-cycle pulse honoured only in IDLE; done pulses once per accepted start.
module mul_alu
  import mul_pkg::*;
#(
  parameter int MUL_WIDTH = 32
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic                 signed_op,
  input  logic [MUL_WIDTH-1:0] multiplicand,
  input  logic [MUL_WIDTH-1:0] multiplier,
  input  logic                 start,
  output logic                 mul_is_running,
  output logic [MUL_WIDTH-1:0] product_hi,
  output logic [MUL_WIDTH-1:0] product_lo,
  output logic                 done,
  output mul_state_e           dbg_state
);

  localparam int EXT_W = MUL_WIDTH + 2;
  localparam int ACC_W = MUL_WIDTH + 4;

  mul_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [EXT_W-1:0]     mplr_q, mplr_d;
  logic                 prev_q, prev_d;
  logic [EXT_W-1:0]     mcand_q, mcand_d;
  logic [MUL_WIDTH-1:0] hi_q, hi_d;
  logic [MUL_WIDTH-1:0] lo_q, lo_d;
  logic                 done_q, done_d;

  booth_t           digit;
  logic [ACC_W-1:0] mcand_acc;
  logic [ACC_W-1:0] pp_mag;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_sh;
  logic [EXT_W-1:0] mplr_sh;
  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;

  mul_alu_booth_enc u_booth_enc (
    .window ({mplr_q[1:0], prev_q}),
    .digit  (digit)
  );

  // Extend to 34 bits so a single signed Booth datapath serves MULT and MULTU.
  assign a_ext = signed_op ? {{2{multiplicand[MUL_WIDTH-1]}}, multiplicand}
                           : {2'b00, multiplicand};
  assign b_ext = signed_op ? {{2{multiplier[MUL_WIDTH-1]}}, multiplier}
                           : {2'b00, multiplier};

  always_comb begin
    mcand_acc = {{2{mcand_q[EXT_W-1]}}, mcand_q};
    pp_mag    = '0;
    if (digit.two)      pp_mag = mcand_acc << 1;
    else if (digit.one) pp_mag = mcand_acc;
    pp      = digit.neg ? (~pp_mag + 1'b1) : pp_mag;
    sum     = acc_q + pp;
    acc_sh  = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    mplr_sh = {sum[1:0], mplr_q[EXT_W-1:2]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    prev_d  = prev_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((multiplicand == '0) || (multiplier == '0)) begin
            state_d = ST_DONE;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            mcand_d = a_ext;
            mplr_d  = b_ext;
            prev_d  = 1'b0;
            acc_d   = '0;
            cnt_d   = CNT_W'(MUL_ITER - 1);
          end
        end
      end
      ST_RUN: begin
        acc_d  = acc_sh;
        mplr_d = mplr_sh;
        prev_d = mplr_q[1];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // After the last shift the product sits in {acc, mplr}; keep its low 64 bits.
          state_d = ST_DONE;
          done_d  = 1'b1;
          hi_d    = {acc_sh[MUL_WIDTH-3:0], mplr_sh[EXT_W-1:MUL_WIDTH]};
          lo_d    = mplr_sh[MUL_WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      prev_q  <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      prev_q  <= prev_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign mul_is_running = (state_q == ST_RUN);
  assign product_hi     = hi_q;
  assign product_lo     = lo_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/mul_alu.md
Name: mul_alu

Overview:
- Multi-cycle 32x32 -> 64-bit integer multiplier for MULT/MULTU; the inverse-operation companion to the execute-stage divider.
- Uses the same start / is_running / done handshake as the divider, so the HI/LO issue logic drives both units identically.
- Radix-4 Booth recoding retires 2 multiplier bits per cycle: 17 iteration cycles, with a one-cycle shortcut when either operand is zero.

Parameters:
- MUL_WIDTH, 32, operand width. Product is 2*MUL_WIDTH. Only 32 is verified.
- MUL_ITER, 17, Booth digits per operation, equal to (MUL_WIDTH+2)/2.

Ports:
- cpu_clk  input  1  single clock, rising edge
- cpu_rst  input  1  asynchronous, active-high reset
- signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- multiplicand  input  32  operand A; sampled with start
- multiplier  input  32  operand B; sampled with start
- start  input  1  single-cycle request pulse; honoured only in IDLE
- mul_is_running  output  1  high while in RUN
- product_hi  output  32  upper half of result (HI); registered
- product_lo  output  32  lower half of result (LO); registered
- done  output  1  one-cycle completion pulse; registered

Behaviour:
- Reset (async, active-high): state=IDLE. mul_is_running, done, product_hi and product_lo all =0. Internal accumulator and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE + start, with either operand == 0 -> DONE. Product registers <= 0.
- IDLE + start, both operands nonzero -> RUN. Latch operands. Iteration counter <= MUL_ITER-1. Accumulator <= 0.
- Operand extension: operands are extended to 34 bits. When signed_op=1, sign-extend. When signed_op=0, zero-extend. This lets one 17-digit Booth datapath cover both MULT and MULTU.
- RUN, each cycle:
  - Recode one Booth digit in {-2,-1,0,+1,+2} from multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Add digit*multiplicand to the upper accumulator, sign-correct to 36 bits.
  - Arithmetic-shift the {accumulator, multiplier} pair right by 2.
  - Decrement the counter.
- RUN with counter == 0: that cycle performs the last digit. Next state is DONE, and product_hi/product_lo are loaded with the low 64 bits of the exact product.
- DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- Latency: start sampled at edge E0.
  - Normal operation: RUN occupies cycles 1..17, done is high in cycle 18, result is valid from cycle 18 onward.
  - Zero shortcut: done is high in cycle 1.
- Result hold: product_hi/product_lo change only on completion or reset. They hold their value indefinitely and are never cleared by a new start.
- start while in RUN or DONE is ignored. No queueing, no restart, operands are not re-sampled.
- mul_is_running is low in IDLE and DONE. The issue stage stalls on mul_is_running | start.
- Operand changes after the start cycle have no effect.
- Reset asserted mid-RUN aborts immediately: no done pulse, products =0.
- Arithmetic: results are exact modulo 2^64. No overflow flag.
  - signed: {hi,lo} = sext(A)*sext(B)
  - unsigned: {hi,lo} = zext(A)*zext(B)

Decomposition:
- Shared package mul_pkg holds:
  - state encoding (IDLE, RUN, DONE)
  - MUL_ITER and the counter width (5 bits)
  - Booth digit encoding: a 3-bit {neg, two, one} one-hot-ish code
- One sub-module, booth_enc: purely combinational. Maps a 3-bit multiplier window to {neg, two, one}; the partial-product mux lives in mul_alu.
- Everything else (accumulator, counter, FSM) stays in mul_alu.

Test Plan:
- Unsigned max, MULTU 0xFFFFFFFF*0xFFFFFFFF, start in cycle 0 -> mul_is_running high in cycles 1..17; done in cycle 18 only; hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed sign, MULT 7*0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same operands with MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
- Signed corner, MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000*0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- Zero shortcut, MULT 0x00000000*0x12345678 -> no RUN cycles, done in cycle 1, hi=lo=0. A previous nonzero result is overwritten.
- Busy and hold: pulse start with new operands at cycle 5 of a running op -> ignored; the original result and done timing are unchanged. Products then stay stable for 20 idle cycles.
- Reset mid-op: assert cpu_rst asynchronously at cycle 9 of RUN -> all outputs 0 immediately, no done pulse. After release, a new start completes normally with a correct 18-cycle latency.
- Randomized 10k operand pairs with random signed_op -> each result matches a 64-bit reference multiply. Every start yields exactly one done.
